// File: rtl/alu_trojan_triggered.sv
// Registered WIDTH-bit ALU with a dormant Trojan that is armed by a three-operand
// ADD sequence and then corrupts PAYLOAD_LEN valid results.
module alu_trojan_triggered #(
    parameter int               WIDTH        = 8,
    parameter bit               TROJAN_EN    = 1'b1,
    parameter logic [WIDTH-1:0] TRIG_SEQ0    = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] TRIG_SEQ1    = WIDTH'(8'h5A),
    parameter logic [WIDTH-1:0] TRIG_SEQ2    = WIDTH'(8'hC3),
    parameter int               PAYLOAD_LEN  = 4,
    parameter int               PAYLOAD_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             dbg_armed
);

    localparam int CW = $clog2(PAYLOAD_LEN + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] S1    = 2'd1;
    localparam logic [1:0] S2    = 2'd2;
    localparam logic [1:0] ARMED = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [1:0]       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c, res_f;
    logic             carry_c, carry_f, ov_c, zero_f, corrupt;
    logic             m0, m1, m2;

    always_comb begin
        sum     = '0;
        res_c   = '0;
        carry_c = 1'b0;
        ov_c    = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, A} + {1'b0, B};
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ov_c    = (A[WIDTH-1] == B[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ov_c    = (A[WIDTH-1] != B[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  res_c = A & B;
            default: res_c = A | B;
        endcase
    end

    // Payload is applied on top of the clean result; zero follows the final result
    // except in mode 1, where the flag itself is the corruption target.
    always_comb begin
        corrupt = TROJAN_EN && (state == ARMED);
        res_f   = res_c;
        carry_f = carry_c;
        if (corrupt && PAYLOAD_MODE == 0) res_f[0] = ~res_c[0];
        if (corrupt && PAYLOAD_MODE == 2) carry_f = ~carry_c;
        zero_f = (res_f == '0);
        if (corrupt && PAYLOAD_MODE == 1) zero_f = 1'b0;
    end

    always_comb begin
        m0      = (op == OP_ADD) && (A == TRIG_SEQ0);
        m1      = (op == OP_ADD) && (A == TRIG_SEQ1);
        m2      = (op == OP_ADD) && (A == TRIG_SEQ2);
        state_n = state;
        cnt_n   = cnt;
        if (in_valid) begin
            case (state)
                IDLE: if (m0) state_n = S1;
                S1:   state_n = m1 ? S2 : (m0 ? S1 : IDLE);
                S2: begin
                    if (m2) begin
                        state_n = ARMED;
                        cnt_n   = CW'(PAYLOAD_LEN);
                    end else begin
                        state_n = m0 ? S1 : IDLE;
                    end
                end
                default: begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) state_n = IDLE;
                end
            endcase
        end
        if (!TROJAN_EN) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res_f;
                carry    <= carry_f;
                zero     <= zero_f;
                overflow <= ov_c;
            end
        end
    end

    assign dbg_armed = (state == ARMED);

endmodule

// File: tb/tb_alu_trojan_triggered.sv
// Bench for alu_trojan_triggered: four configurations (payload modes 0/1/2 and a
// clean build) share one stimulus stream and are checked against a sequence model.
module tb_alu_trojan_triggered;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [1:0] op_in = '0;

    logic       ovld_o [4];
    logic [7:0] res_o  [4];
    logic       c_o    [4];
    logic       z_o    [4];
    logic       ov_o   [4];
    logic       arm_o  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_trojan_triggered #(.WIDTH(8), .TROJAN_EN(1'b1), .PAYLOAD_LEN(4), .PAYLOAD_MODE(0)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_in), .B(b_in), .op(op_in),
        .out_valid(ovld_o[0]), .result(res_o[0]), .carry(c_o[0]), .zero(z_o[0]),
        .overflow(ov_o[0]), .dbg_armed(arm_o[0]));
    alu_trojan_triggered #(.WIDTH(8), .TROJAN_EN(1'b1), .PAYLOAD_LEN(4), .PAYLOAD_MODE(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_in), .B(b_in), .op(op_in),
        .out_valid(ovld_o[1]), .result(res_o[1]), .carry(c_o[1]), .zero(z_o[1]),
        .overflow(ov_o[1]), .dbg_armed(arm_o[1]));
    alu_trojan_triggered #(.WIDTH(8), .TROJAN_EN(1'b1), .PAYLOAD_LEN(4), .PAYLOAD_MODE(2)) dut_m2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_in), .B(b_in), .op(op_in),
        .out_valid(ovld_o[2]), .result(res_o[2]), .carry(c_o[2]), .zero(z_o[2]),
        .overflow(ov_o[2]), .dbg_armed(arm_o[2]));
    alu_trojan_triggered #(.WIDTH(8), .TROJAN_EN(1'b0), .PAYLOAD_LEN(4), .PAYLOAD_MODE(0)) dut_cl (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a_in), .B(b_in), .op(op_in),
        .out_valid(ovld_o[3]), .result(res_o[3]), .carry(c_o[3]), .zero(z_o[3]),
        .overflow(ov_o[3]), .dbg_armed(arm_o[3]));

    // ---------------- reference model ----------------
    bit         cfg_en   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int         cfg_mode [4] = '{0, 1, 2, 0};
    logic [9:0] hist[$];
    bit         armed_m = 1'b0;
    int         remaining = 0;
    logic [7:0] trig [3];

    logic       e_ovld [4];
    logic [7:0] e_res  [4];
    logic       e_c    [4];
    logic       e_z    [4];
    logic       e_ov   [4];
    logic       e_arm  [4];

    task automatic model_reset();
        armed_m   = 1'b0;
        remaining = 0;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            e_ovld[i] = 0; e_res[i] = 0; e_c[i] = 0; e_z[i] = 0; e_ov[i] = 0; e_arm[i] = 0;
        end
    endtask

    task automatic model_step(input bit valid, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] b);
        int ua, ub, sa, sb, r, c, ov, s;
        bit hit;
        for (int i = 0; i < 4; i++) e_ovld[i] = valid;
        if (valid) begin
            ua = a; ub = b; sa = $signed(a); sb = $signed(b);
            c = 0; ov = 0;
            case (op)
                2'b00: begin r = (ua + ub) % 256; c = (ua + ub > 255); s = sa + sb; ov = (s > 127 || s < -128); end
                2'b01: begin r = (ua - ub + 256) % 256; c = (ua >= ub); s = sa - sb; ov = (s > 127 || s < -128); end
                2'b10: r = ua & ub;
                default: r = ua | ub;
            endcase
            for (int i = 0; i < 4; i++) begin
                e_res[i] = 8'(r); e_c[i] = c[0]; e_ov[i] = ov[0];
                if (cfg_en[i] && armed_m && cfg_mode[i] == 0) e_res[i] = 8'(r ^ 1);
                if (cfg_en[i] && armed_m && cfg_mode[i] == 2) e_c[i] = ~c[0];
                e_z[i] = (e_res[i] == 0);
                if (cfg_en[i] && armed_m && cfg_mode[i] == 1) e_z[i] = 1'b0;
            end
            if (armed_m) begin
                remaining--;
                if (remaining == 0) armed_m = 1'b0;
            end else begin
                hist.push_back({op, a});
                if (hist.size() > 3) void'(hist.pop_front());
                hit = (hist.size() == 3) && hist[0] == {2'b00, trig[0]} &&
                      hist[1] == {2'b00, trig[1]} && hist[2] == {2'b00, trig[2]};
                if (hit) begin
                    armed_m = 1'b1;
                    remaining = 4;
                    hist.delete();
                end
            end
        end
        for (int i = 0; i < 4; i++) e_arm[i] = cfg_en[i] && armed_m;
    endtask

    task automatic check_all(input string name);
        logic [12:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            got = {ovld_o[i], res_o[i], c_o[i], z_o[i], ov_o[i], arm_o[i]};
            exp = {e_ovld[i], e_res[i], e_c[i], e_z[i], e_ov[i], e_arm[i]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s dut%0d: got {vld,res,c,z,ov,arm}=%h expected %h", name, i, got, exp);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input bit valid, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input string name);
        in_valid = valid; op_in = op; a_in = a; b_in = b;
        @(posedge clk);
        model_step(valid, op, a, b);
        #1;
        check_all(name);
    endtask

    // Called 1 time unit after a rising edge: assert, check asynchronously, release.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(name);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- directed table (mode-0 instance) ----------------
    typedef struct {
        bit         valid;
        logic [1:0] op;
        logic [7:0] a, b, r;
        bit         c, z, ov, arm;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit v, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                logic [7:0] r, bit c, bit z, bit ov, bit arm);
        vec_t t;
        t.valid = v; t.op = op; t.a = a; t.b = b; t.r = r; t.c = c; t.z = z; t.ov = ov; t.arm = arm;
        return t;
    endfunction

    initial begin
        logic [12:0] got, exp;
        trig[0] = 8'hA5; trig[1] = 8'h5A; trig[2] = 8'hC3;

        tbl.push_back(mk(1, 2'b00, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2'b01, 8'h80, 8'h01, 8'h7F, 1, 0, 1, 0));
        tbl.push_back(mk(1, 2'b00, 8'hA5, 8'h00, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'h5A, 8'h00, 8'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 8'hFF, 8'hFF, 8'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hC3, 8'h00, 8'hC3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 8'h10, 8'h01, 8'h10, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 8'h10, 8'h01, 8'h10, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 8'h10, 8'h01, 8'h10, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 8'h10, 8'h01, 8'h10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'h10, 8'h01, 8'h11, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hA5, 8'h00, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'h5A, 8'h00, 8'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hC3, 8'h00, 8'hC3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hA5, 8'h00, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hA5, 8'h00, 8'hA5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'h5A, 8'h00, 8'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 8'hC3, 8'h00, 8'hC3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 8'hFF, 8'h0F, 8'h0E, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 8'hFF, 8'h0F, 8'h0E, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 8'hFF, 8'h0F, 8'h0E, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2'b10, 8'hFF, 8'h0F, 8'h0E, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2'b11, 8'h0F, 8'hF0, 8'hFF, 0, 0, 0, 0));

        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset_initial");

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].valid, tbl[k].op, tbl[k].a, tbl[k].b, $sformatf("model_vec%0d", k));
            got = {ovld_o[0], res_o[0], c_o[0], z_o[0], ov_o[0], arm_o[0]};
            exp = {tbl[k].valid, tbl[k].r, tbl[k].c, tbl[k].z, tbl[k].ov, tbl[k].arm};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL table_vec%0d: got {vld,res,c,z,ov,arm}=%h expected %h", k, got, exp);
            end
            if (k == 7) begin
                check_val("clean_build_result", res_o[3], 8'h11);
                check_val("clean_build_armed", {7'b0, arm_o[3]}, 8'h00);
            end
        end

        // Mode 1: reset in the middle of a payload burst.
        apply(1, 2'b00, 8'hA5, 8'h00, "m1_trig0");
        apply(1, 2'b00, 8'h5A, 8'h00, "m1_trig1");
        apply(1, 2'b00, 8'hC3, 8'h00, "m1_trig2");
        for (int k = 0; k < 2; k++) begin
            apply(1, 2'b00, 8'h00, 8'h00, "m1_payload");
            check_val("m1_zero_forced", {7'b0, z_o[1]}, 8'h00);
            check_val("m1_armed", {7'b0, arm_o[1]}, 8'h01);
        end
        do_reset("reset_mid_payload");
        check_val("m1_armed_after_reset", {7'b0, arm_o[1]}, 8'h00);
        apply(1, 2'b00, 8'h00, 8'h00, "m1_after_reset");
        check_val("m1_zero_clean", {7'b0, z_o[1]}, 8'h01);
        check_val("m0_result_clean", res_o[0], 8'h00);

        // Random traffic biased toward trigger operands so bursts actually occur.
        for (int n = 0; n < 600; n++) begin
            bit         v;
            logic [1:0] o;
            logic [7:0] av, bv;
            v  = ($urandom_range(0, 3) != 0);
            o  = 2'($urandom_range(0, 3));
            av = 8'($urandom);
            bv = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                o  = 2'b00;
                av = trig[$urandom_range(0, 2)];
            end
            if ($urandom_range(0, 149) == 0) do_reset("reset_random");
            apply(v, o, av, bv, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_trojan_triggered.md
Name: alu_trojan_triggered

Overview:
- Parametrised, registered ALU used as a positive-control benchmark for Trojan detection.
- Wraps a clean WIDTH-bit ALU datapath together with a dormant, sequence-triggered Trojan.
- The Trojan corrupts a bounded number of results once a magic operand sequence has been seen.
- Successor to the 4-bit always-on counter variant: generalised in width, payload mode and trigger, with a valid handshake. With TROJAN_EN=0 it behaves as the clean ALU.

Parameters:
WIDTH, 8, operand/result width (>=4)
TROJAN_EN, 1, 1 = Trojan logic present; 0 = clean behaviour, FSM held in IDLE
TRIG_SEQ0, 8'hA5, first trigger operand (WIDTH bits)
TRIG_SEQ1, 8'h5A, second trigger operand
TRIG_SEQ2, 8'hC3, third trigger operand
PAYLOAD_LEN, 4, number of valid transactions corrupted once armed (>=1)
PAYLOAD_MODE, 0, 0 = invert result[0]; 1 = force zero flag to 0; 2 = invert carry

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
out_valid  output  1  registered result valid
result  output  WIDTH  registered result
carry  output  1  carry flag
zero  output  1  result == 0 (after payload applied)
overflow  output  1  signed overflow flag
dbg_armed  output  1  Trojan FSM in ARMED (bench observability)

Behaviour:
- Reset (async assert, sync release): out_valid, result, carry, zero, overflow, dbg_armed = 0; FSM = IDLE; payload counter = 0.
- Latency is 1 cycle. out_valid is a registered copy of in_valid. Result and flags update only when in_valid=1 and hold otherwise. No backpressure.
- ADD: {carry,result} = A+B (WIDTH+1 bits). Overflow = signs of A and B equal and sign of result differs.
- SUB: computed as A + ~B + 1. carry = carry-out (1 = no borrow). Overflow = signs of A and B differ and sign of result differs from A.
- AND/OR: bitwise; carry = 0, overflow = 0.
- zero is computed on the final (possibly corrupted) result, except in PAYLOAD_MODE 1.
- Trigger FSM states: IDLE, S1, S2, ARMED. It advances only on in_valid=1.
- A transaction counts as matching step k only if op=ADD and A=TRIG_SEQk.
- IDLE: match SEQ0 -> S1; else stay in IDLE.
- S1: match SEQ1 -> S2; else match SEQ0 -> S1; else -> IDLE.
- S2: match SEQ2 -> ARMED and load payload counter = PAYLOAD_LEN; else match SEQ0 -> S1; else -> IDLE.
- The transaction that completes the trigger is itself output clean.
- ARMED: every valid transaction, of any op and any operands, is corrupted per PAYLOAD_MODE and decrements the counter. Operands are ignored for trigger purposes in this state.
- When the counter reaches 0 on a valid transaction, the FSM goes to IDLE. That transaction is the last one corrupted.
- in_valid=0 cycles: FSM and counter hold, so the trigger sequence may be non-contiguous in time.
- dbg_armed = 1 exactly while the FSM is in ARMED (registered state).
- Reset mid-payload: FSM returns to IDLE, counter clears, and the next transaction is clean.
- TROJAN_EN=0: FSM forced to IDLE, dbg_armed constant 0, no corruption ever.
- Payload counter width is clog2(PAYLOAD_LEN+1).

Test Plan:
- Reset asserted mid-stream -> all outputs 0 asynchronously, out_valid=0, dbg_armed=0.
- ADD A=8'hFF, B=8'h01 -> next cycle out_valid=1, result=8'h00, carry=1, zero=1, overflow=0. SUB A=8'h80, B=8'h01 -> result=8'h7F, carry=1, overflow=1, zero=0.
- ADD with A=A5, then 5A, then C3 (B=00, one in_valid=0 gap between them) -> those three results clean, dbg_armed=1 after the third. Next four ADD 8'h10+8'h01 -> result 8'h10 (mode 0). The fifth -> 8'h11, dbg_armed=0.
- Broken sequence A5, 5A, 00, C3 -> never arms, all results clean. Sequence A5, A5, 5A, C3 -> arms (S1 self-loop).
- Armed with PAYLOAD_MODE=1; after 2 corrupted transactions assert reset -> dbg_armed=0; next ADD 8'h00+8'h00 -> zero=1 (clean).
- TROJAN_EN=0; full trigger sequence then ADD 8'h10+8'h01 -> result 8'h11, dbg_armed stays 0.
